// File: rtl/grid_move_engine.sv
// Player-position engine for a tile grid. It resolves each accepted move by fetching the
// target tile from a synchronous map memory, then commits the move or reports a collision.
module grid_move_engine #(
    parameter int unsigned      COORD_W   = 5,
    parameter int unsigned      GRID_W    = 32,
    parameter int unsigned      GRID_H    = 32,
    parameter int unsigned      MAP_SEL_W = 2,
    parameter int unsigned      TILE_W    = 2,
    parameter logic [TILE_W-1:0] WALL_CODE = TILE_W'(1),
    parameter bit               WRAP      = 1'b0,
    parameter int unsigned      START_X   = 0,
    parameter int unsigned      START_Y   = 0,
    parameter int unsigned      COUNT_W   = 8
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           move_valid,
    input  logic [2:0]                     move,
    input  logic [MAP_SEL_W-1:0]           map_sel,
    output logic                           move_ready,
    input  logic                           load_en,
    input  logic [COORD_W-1:0]             load_x,
    input  logic [COORD_W-1:0]             load_y,
    output logic                           tile_rd,
    output logic [MAP_SEL_W+2*COORD_W-1:0] tile_addr,
    input  logic [TILE_W-1:0]              tile_data,
    output logic [COORD_W-1:0]             pos_x,
    output logic [COORD_W-1:0]             pos_y,
    output logic                           done,
    output logic                           blocked,
    output logic [COUNT_W-1:0]             collision_count
);

    localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W-1:0] X_START = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] Y_START = COORD_W'(START_Y);

    localparam logic [2:0] MOVE_UP    = 3'd1;
    localparam logic [2:0] MOVE_DOWN  = 3'd2;
    localparam logic [2:0] MOVE_LEFT  = 3'd3;
    localparam logic [2:0] MOVE_RIGHT = 3'd4;

    typedef enum logic [1:0] {StIdle, StFetch, StCheck} state_t;

    // How a latched move gets resolved in CHECK.
    typedef enum logic [1:0] {KindNone, KindEdge, KindFetch} kind_t;

    state_t             state;
    kind_t              kind;
    kind_t              lat_kind;
    logic [COORD_W-1:0] tgt_x;
    logic [COORD_W-1:0] tgt_y;
    logic [COORD_W-1:0] lat_x;
    logic [COORD_W-1:0] lat_y;

    assign move_ready = (state == StIdle) && !load_en;

    // Target decode; a step off the grid either wraps or is flagged as an edge hit.
    always_comb begin
        tgt_x = pos_x;
        tgt_y = pos_y;
        kind  = KindFetch;
        case (move)
            MOVE_UP: begin
                if (pos_y == '0) begin
                    if (WRAP) tgt_y = Y_MAX;
                    else      kind  = KindEdge;
                end else begin
                    tgt_y = pos_y - 1'b1;
                end
            end
            MOVE_DOWN: begin
                if (pos_y >= Y_MAX) begin
                    if (WRAP) tgt_y = '0;
                    else      kind  = KindEdge;
                end else begin
                    tgt_y = pos_y + 1'b1;
                end
            end
            MOVE_LEFT: begin
                if (pos_x == '0) begin
                    if (WRAP) tgt_x = X_MAX;
                    else      kind  = KindEdge;
                end else begin
                    tgt_x = pos_x - 1'b1;
                end
            end
            MOVE_RIGHT: begin
                if (pos_x >= X_MAX) begin
                    if (WRAP) tgt_x = '0;
                    else      kind  = KindEdge;
                end else begin
                    tgt_x = pos_x + 1'b1;
                end
            end
            default: kind = KindNone;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= StIdle;
            lat_kind        <= KindNone;
            lat_x           <= '0;
            lat_y           <= '0;
            pos_x           <= X_START;
            pos_y           <= Y_START;
            done            <= 1'b0;
            blocked         <= 1'b0;
            tile_rd         <= 1'b0;
            tile_addr       <= '0;
            collision_count <= '0;
        end else begin
            done    <= 1'b0;
            tile_rd <= 1'b0;
            case (state)
                StIdle: begin
                    if (load_en) begin
                        pos_x <= load_x;
                        pos_y <= load_y;
                    end else if (move_valid) begin
                        lat_kind <= kind;
                        lat_x    <= tgt_x;
                        lat_y    <= tgt_y;
                        if (kind == KindFetch) begin
                            tile_rd   <= 1'b1;
                            tile_addr <= {map_sel, tgt_y, tgt_x};
                        end
                        state <= StFetch;
                    end
                end
                StFetch: state <= StCheck;
                StCheck: begin
                    done  <= 1'b1;
                    state <= StIdle;
                    case (lat_kind)
                        KindNone: blocked <= 1'b0;
                        KindEdge: begin
                            blocked <= 1'b1;
                            if (collision_count != '1) collision_count <= collision_count + 1'b1;
                        end
                        default: begin
                            if (tile_data == WALL_CODE) begin
                                blocked <= 1'b1;
                                if (collision_count != '1) begin
                                    collision_count <= collision_count + 1'b1;
                                end
                            end else begin
                                blocked <= 1'b0;
                                pos_x   <= lat_x;
                                pos_y   <= lat_y;
                            end
                        end
                    endcase
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_move_engine.sv
// Bench for grid_move_engine: a clamping and a wrapping instance share stimulus and a map
// memory, and each is checked against a coordinate-arithmetic model of the grid.
module tb_grid_move_engine;

    logic        clk = 1'b0;
    logic        resetn;
    logic        move_valid;
    logic [2:0]  move;
    logic [1:0]  map_sel;
    logic        load_en;
    logic [4:0]  load_x;
    logic [4:0]  load_y;

    logic        rdy  [2];
    logic        trd  [2];
    logic [11:0] taddr[2];
    logic [1:0]  tdata[2];
    logic [4:0]  px   [2];
    logic [4:0]  py   [2];
    logic        dn   [2];
    logic        blk  [2];
    logic [7:0]  cnt  [2];

    logic [1:0]  mem  [0:4095];

    int m_x  [2];
    int m_y  [2];
    int m_cnt[2];
    bit m_blk[2];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Synchronous map memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (trd[i]) tdata[i] <= mem[taddr[i]];
        end
    end

    grid_move_engine #(.WRAP(1'b0)) u_clamp (
        .clk(clk), .resetn(resetn), .move_valid(move_valid), .move(move), .map_sel(map_sel),
        .move_ready(rdy[0]), .load_en(load_en), .load_x(load_x), .load_y(load_y),
        .tile_rd(trd[0]), .tile_addr(taddr[0]), .tile_data(tdata[0]), .pos_x(px[0]),
        .pos_y(py[0]), .done(dn[0]), .blocked(blk[0]), .collision_count(cnt[0])
    );

    grid_move_engine #(.WRAP(1'b1)) u_wrap (
        .clk(clk), .resetn(resetn), .move_valid(move_valid), .move(move), .map_sel(map_sel),
        .move_ready(rdy[1]), .load_en(load_en), .load_x(load_x), .load_y(load_y),
        .tile_rd(trd[1]), .tile_addr(taddr[1]), .tile_data(tdata[1]), .pos_x(px[1]),
        .pos_y(py[1]), .done(dn[1]), .blocked(blk[1]), .collision_count(cnt[1])
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_cnt[i] = 0; m_blk[i] = 0;
        end
    endtask

    // Instance 0 clamps at the grid edge, instance 1 wraps around a 32x32 grid.
    task automatic model_move(input int i, input logic [2:0] mv, input logic [1:0] sel,
                              output bit rd, output int addr);
        int  nx = m_x[i];
        int  ny = m_y[i];
        bit  fetch = 1;
        rd = 0;
        addr = 0;
        case (mv)
            3'd1: ny = ny - 1;
            3'd2: ny = ny + 1;
            3'd3: nx = nx - 1;
            3'd4: nx = nx + 1;
            default: fetch = 0;
        endcase
        if (!fetch) begin
            m_blk[i] = 0;
        end else if ((nx < 0 || nx > 31 || ny < 0 || ny > 31) && i == 0) begin
            m_blk[i] = 1;
            if (m_cnt[i] < 255) m_cnt[i]++;
        end else begin
            nx = (nx + 32) % 32;
            ny = (ny + 32) % 32;
            rd = 1;
            addr = int'(sel) * 1024 + ny * 32 + nx;
            if (mem[addr] == 2'b01) begin
                m_blk[i] = 1;
                if (m_cnt[i] < 255) m_cnt[i]++;
            end else begin
                m_blk[i] = 0;
                m_x[i] = nx;
                m_y[i] = ny;
            end
        end
    endtask

    task automatic clear_map();
        for (int a = 0; a < 4096; a++) mem[a] = 2'b00;
    endtask

    task automatic random_map();
        for (int a = 0; a < 4096; a++) mem[a] = 2'($urandom_range(0, 3));
    endtask

    task automatic do_load(input int x, input int y);
        @(negedge clk);
        load_en = 1'b1;
        load_x = 5'(x);
        load_y = 5'(y);
        @(posedge clk);
        #1;
        load_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_x[i] = x;
            m_y[i] = y;
            vectors++;
            if (px[i] !== 5'(x) || py[i] !== 5'(y)) begin
                miscompares++;
                $display("FAIL load_pos[%0d]: got (%0d,%0d) want (%0d,%0d)", i, px[i], py[i], x, y);
            end
        end
    endtask

    // Accept at E0, read strobe in the cycle after E0, done in the cycle after E2.
    task automatic do_move(input logic [2:0] mv, input logic [1:0] sel);
        bit rd[2];
        int addr[2];
        @(negedge clk);
        move_valid = 1'b1;
        move = mv;
        map_sel = sel;
        for (int i = 0; i < 2; i++) begin
            model_move(i, mv, sel, rd[i], addr[i]);
            vectors++;
            if (rdy[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL move_ready[%0d]: got %b want 1", i, rdy[i]);
            end
        end
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        move = 3'd0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (trd[i] !== rd[i] || (rd[i] && taddr[i] !== 12'(addr[i]))) begin
                miscompares++;
                $display("FAIL fetch[%0d]: got rd=%b addr=%0h want rd=%b addr=%0h",
                         i, trd[i], taddr[i], rd[i], addr[i]);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (dn[i] !== 1'b0 || trd[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL early_done[%0d]: got done=%b rd=%b want 0 0", i, dn[i], trd[i]);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (dn[i] !== 1'b1 || px[i] !== 5'(m_x[i]) || py[i] !== 5'(m_y[i]) ||
                blk[i] !== m_blk[i] || cnt[i] !== 8'(m_cnt[i])) begin
                miscompares++;
                $display("FAIL result[%0d] mv=%0d: got done=%b pos=(%0d,%0d) blk=%b cnt=%0d want 1 (%0d,%0d) %b %0d",
                         i, mv, dn[i], px[i], py[i], blk[i], cnt[i],
                         m_x[i], m_y[i], m_blk[i], m_cnt[i]);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (px[i] !== 5'd0 || py[i] !== 5'd0 || dn[i] !== 1'b0 || blk[i] !== 1'b0 ||
                trd[i] !== 1'b0 || taddr[i] !== 12'd0 || cnt[i] !== 8'd0 || rdy[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL %s[%0d]: got pos=(%0d,%0d) done=%b blk=%b rd=%b addr=%0h cnt=%0d rdy=%b want all zero, rdy=1",
                         tag, i, px[i], py[i], dn[i], blk[i], trd[i], taddr[i], cnt[i], rdy[i]);
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; move_valid = 1'b0; move = 3'd0; map_sel = 2'd0;
        load_en = 1'b0; load_x = 5'd0; load_y = 5'd0;
        model_reset();
        #12;
        check_idle_outputs("reset_held");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("reset_released");
    endtask

    task automatic test_first_move();
        clear_map();
        do_move(3'd4, 2'd0);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (px[i] !== 5'd1 || py[i] !== 5'd0 || blk[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL first_right[%0d]: got (%0d,%0d) blk=%b want (1,0) 0", i, px[i], py[i], blk[i]);
            end
        end
    endtask

    task automatic test_wall();
        do_load(5, 5);
        mem[6 * 32 + 5] = 2'b01;
        do_move(3'd2, 2'd0);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (px[i] !== 5'd5 || py[i] !== 5'd5 || blk[i] !== 1'b1 || cnt[i] !== 8'd1) begin
                miscompares++;
                $display("FAIL wall[%0d]: got (%0d,%0d) blk=%b cnt=%0d want (5,5) 1 1",
                         i, px[i], py[i], blk[i], cnt[i]);
            end
        end
    endtask

    task automatic test_edge();
        clear_map();
        do_load(0, 3);
        do_move(3'd3, 2'd0);
        vectors++;
        if (px[0] !== 5'd0 || blk[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL edge_clamp: got x=%0d blk=%b want 0 1", px[0], blk[0]);
        end
        vectors++;
        if (px[1] !== 5'd31 || py[1] !== 5'd3 || blk[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL edge_wrap: got (%0d,%0d) blk=%b want (31,3) 0", px[1], py[1], blk[1]);
        end
    endtask

    task automatic test_load_priority();
        @(negedge clk);
        load_en = 1'b1; move_valid = 1'b1; move = 3'd4; load_x = 5'd7; load_y = 5'd9;
        #1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (rdy[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL load_ready[%0d]: got %b want 0", i, rdy[i]);
            end
        end
        @(posedge clk);
        #1;
        load_en = 1'b0; move_valid = 1'b0; move = 3'd0;
        for (int i = 0; i < 2; i++) begin
            m_x[i] = 7; m_y[i] = 9;
            vectors++;
            if (px[i] !== 5'd7 || py[i] !== 5'd9) begin
                miscompares++;
                $display("FAIL load_wins[%0d]: got (%0d,%0d) want (7,9)", i, px[i], py[i]);
            end
        end
        repeat (4) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (dn[i] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL load_no_done[%0d]: got %b want 0", i, dn[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int last = -1;
        clear_map();
        do_load(0, 0);
        @(negedge clk);
        move_valid = 1'b1; move = 3'd4; map_sel = 2'd0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (dn[0] === 1'b1) begin
                if (last >= 0) begin
                    vectors++;
                    if (c - last !== 3) begin
                        miscompares++;
                        $display("FAIL b2b_gap: got %0d cycles want 3", c - last);
                    end
                end
                last = c;
                pulses++;
                if (pulses == 4) begin
                    move_valid = 1'b0;
                    break;
                end
            end
        end
        move_valid = 1'b0;
        move = 3'd0;
        vectors++;
        if (pulses != 4) begin
            miscompares++;
            $display("FAIL b2b_pulses: got %0d want 4", pulses);
        end
        for (int i = 0; i < 2; i++) begin
            m_x[i] = 4; m_y[i] = 0; m_blk[i] = 0;
            vectors++;
            if (px[i] !== 5'd4 || py[i] !== 5'd0) begin
                miscompares++;
                $display("FAIL b2b_pos[%0d]: got (%0d,%0d) want (4,0)", i, px[i], py[i]);
            end
        end
    endtask

    task automatic test_random();
        random_map();
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_load(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            end else begin
                do_move(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_load(10, 10);
        @(negedge clk);
        move_valid = 1'b1; move = 3'd4;
        @(posedge clk);
        #1;
        move_valid = 1'b0; move = 3'd0;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        model_reset();
        #1;
        check_idle_outputs("reset_mid");
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (dn[i] !== 1'b0 || px[i] !== 5'd0 || py[i] !== 5'd0) begin
                    miscompares++;
                    $display("FAIL reset_abort[%0d]: got done=%b pos=(%0d,%0d) want 0 (0,0)",
                             i, dn[i], px[i], py[i]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        clear_map();
        mem[6 * 32 + 5] = 2'b01;
        do_load(5, 5);
        repeat (256) do_move(3'd2, 2'd0);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (cnt[i] !== 8'd255) begin
                miscompares++;
                $display("FAIL saturate[%0d]: got %0d want 255", i, cnt[i]);
            end
        end
        do_move(3'd0, 2'd0);
    endtask

    initial begin
        test_reset();
        test_first_move();
        test_wall();
        test_edge();
        test_load_priority();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
